// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings and parameter defaults for mem_port_arbiter.
// Contents: FSM state enum, grant encoding, default ACK_TIMEOUT and ABORT_DATA.
package mem_arb_pkg;
    typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} arb_state_e;
    typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} gnt_e;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;
    localparam logic [31:0] DEF_ABORT_DATA  = 32'h0000_0000;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU fetch port, CPU data port and the shared memory handshake.
// Modports: slave = arbiter view (takes CPU requests, drives memory); master = CPU/memory-side view.
interface mem_port_arbiter_if;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        arb_err;
    modport slave (
        input  inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
        output inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata, arb_err
    );
    modport master (
        output inst_ren, inst_addr, mem_ren, mem_wen, mem_addr, mem_dout, ram_rdata, ram_ack,
        input  inst_data, inst_stall, mem_din, mem_stall, ram_req, ram_we, ram_addr, ram_wdata, arb_err
    );
endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// mem_arb_wdog: 16-bit ack watchdog; clears on clr_i, counts while en_i.
// Ports: clk, rst (async active-low), clr_i, en_i, expired_o (LIMIT-th enabled cycle reached).
module mem_arb_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : (en_i ? cnt_q + 16'd1 : cnt_q);
    // Count includes the current cycle, so LIMIT busy cycles elapse before expiry.
    assign expired_o = en_i & (({1'b0, cnt_q} + 17'd1) == 17'(LIMIT));
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between the CPU fetch and data ports with per-port stalls.
// Ports: clk, rst (async active-low), bus (mem_port_arbiter_if.slave: CPU ports + memory handshake).
// Build option: MEM_ARB_RR_EN selects round-robin on collisions; otherwise the data port always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter logic [31:0] ABORT_DATA  = DEF_ABORT_DATA
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_e  state_q;
    logic        ram_req_q, ram_we_q, arb_err_q;
    logic [31:0] ram_addr_q, ram_wdata_q, inst_data_q, mem_din_q;
    logic        inst_pend, data_pend, gnt_data, busy, expired;
    assign inst_pend = bus.inst_ren;
    assign data_pend = bus.mem_ren | bus.mem_wen;
    assign busy      = (state_q == I_BUSY) || (state_q == D_BUSY);
`ifdef MEM_ARB_RR_EN
    gnt_e last_q;
    // The port that did not win last time gets the collision.
    assign gnt_data = data_pend & (~inst_pend | (last_q == GNT_INST));
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_q <= GNT_INST;
        else if (state_q == IDLE && (inst_pend | data_pend)) last_q <= gnt_data ? GNT_DATA : GNT_INST;
`else
    assign gnt_data = data_pend;
`endif
    mem_arb_wdog #(.LIMIT(ACK_TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q == IDLE),
        .en_i     (busy),
        .expired_o(expired)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
            arb_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (inst_pend | data_pend) begin
                    state_q     <= gnt_data ? D_BUSY : I_BUSY;
                    ram_req_q   <= 1'b1;
                    ram_we_q    <= gnt_data & bus.mem_wen;
                    ram_addr_q  <= gnt_data ? bus.mem_addr : bus.inst_addr;
                    ram_wdata_q <= gnt_data ? bus.mem_dout : '0;
                end
                // An ack arriving in the expiry cycle still counts as a real completion.
                I_BUSY, D_BUSY: if (bus.ram_ack | expired) begin
                    ram_req_q <= 1'b0;
                    state_q   <= (state_q == I_BUSY) ? I_DONE : D_DONE;
                    if (state_q == I_BUSY) inst_data_q <= bus.ram_ack ? bus.ram_rdata : ABORT_DATA;
                    else if (!ram_we_q) mem_din_q <= bus.ram_ack ? bus.ram_rdata : ABORT_DATA;
                    if (!bus.ram_ack) arb_err_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.inst_stall = inst_pend & (state_q != I_DONE);
    assign bus.mem_stall  = data_pend & (state_q != D_DONE);
    assign bus.ram_req    = ram_req_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.arb_err    = arb_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter against a timing/arbitration model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;
    localparam int          T     = 4;
    localparam logic [31:0] ABORT = 32'hDEAD_BEEF;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0, n_err = 0;
    logic [31:0] exp_inst = '0, exp_din = '0;
    bit exp_err = 1'b0;
`ifdef MEM_ARB_RR_EN
    bit last_d = 1'b0;
`endif
    mem_port_arbiter_if bus();
    mem_port_arbiter #(.ACK_TIMEOUT(T), .ABORT_DATA(ABORT)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int mn(input int a, input int b);
        return a < b ? a : b;
    endfunction
    // One transaction set: the selected ports request together; latencies are in request cycles
    // (a latency above T means the memory never answers and the watchdog must abort).
    task automatic run_scn(input bit di, input bit dd, input bit we, input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] dw, input logic [31:0] rdv, input int li, input int ld);
        bit first_d, ai, ad;
        int lat[2];
        logic [31:0] ea[2], rd[2];
        bit ewe[2];
        int acc = 0, rc = 0, k = 0, ci = 0, cd = 0, pi, pd, s1, s2, sti, std, n;
`ifdef MEM_ARB_RR_EN
        first_d = dd && (!di || !last_d);
        last_d  = (di && dd) ? !first_d : dd;
`else
        first_d = dd;
`endif
        lat[0] = first_d ? ld : li;
        lat[1] = first_d ? li : ld;
        ea[0]  = first_d ? da : ia;
        ea[1]  = first_d ? ia : da;
        ewe[0] = first_d && we;
        ewe[1] = !first_d && dd && we;
        rd[0]  = '0;
        rd[1]  = '0;
        pd = first_d ? 0 : 1;
        pi = first_d ? 1 : 0;
        s1 = mn(lat[0], T) + 1;
        s2 = mn(lat[0], T) + mn(lat[1], T) + 3;
        sti = (pi == 0) ? s1 : s2;
        std = (pd == 0) ? s1 : s2;
        n = int'(di) + int'(dd);
        if ((di && li > T) || (dd && ld > T)) exp_err = 1'b1;
        @(negedge clk);
        bus.inst_ren  = di;
        bus.inst_addr = ia;
        bus.mem_ren   = dd && !we;
        bus.mem_wen   = dd && we;
        bus.mem_addr  = da;
        bus.mem_dout  = dw;
        ai = di;
        ad = dd;
        for (int c = 0; c < 60 && (ai || ad); c++) begin
            if (bus.ram_req) begin
                if (rc == 0) begin
                    if (acc < 2) begin
                        chk("ram_addr", bus.ram_addr, ea[acc]);
                        chk("ram_we", 32'(bus.ram_we), 32'(ewe[acc]));
                        if (ewe[acc]) chk("ram_wdata", bus.ram_wdata, dw);
                    end
                    acc++;
                end
                k = (acc > 2) ? 1 : acc - 1;
                rc++;
                bus.ram_rdata = (rdv != 0) ? rdv : $urandom;
                bus.ram_ack   = (acc <= 2) && (rc == lat[k]);
                if (bus.ram_ack) begin
                    rd[k] = bus.ram_rdata;
                    chk("hold_addr", bus.ram_addr, ea[k]);
                    if (ewe[k]) chk("hold_wdata", bus.ram_wdata, dw);
                end
            end else begin
                if (rc != 0) chk("req_len", rc, mn(lat[k], T));
                rc = 0;
                bus.ram_ack   = 1'b0;
                bus.ram_rdata = $urandom;
            end
            #1;
            if (ai) begin
                if (bus.inst_stall) ci++;
                else begin
                    chk("i_stall_len", ci, sti);
                    exp_inst = (lat[pi] <= T) ? rd[pi] : ABORT;
                    chk("inst_data", bus.inst_data, exp_inst);
                    bus.inst_ren = 1'b0;
                    ai = 1'b0;
                end
            end else chk("i_stall_idle", 32'(bus.inst_stall), 0);
            if (ad) begin
                if (bus.mem_stall) cd++;
                else begin
                    chk("d_stall_len", cd, std);
                    if (!we) exp_din = (lat[pd] <= T) ? rd[pd] : ABORT;
                    chk("mem_din", bus.mem_din, exp_din);
                    bus.mem_ren = 1'b0;
                    bus.mem_wen = 1'b0;
                    ad = 1'b0;
                end
            end else chk("d_stall_idle", 32'(bus.mem_stall), 0);
            @(negedge clk);
        end
        chk("complete", {30'd0, ai, ad}, 0);
        bus.ram_ack  = 1'b0;
        bus.inst_ren = 1'b0;
        bus.mem_ren  = 1'b0;
        bus.mem_wen  = 1'b0;
        chk("acc_cnt", acc, n);
        chk("arb_err", 32'(bus.arb_err), 32'(exp_err));
        chk("inst_keep", bus.inst_data, exp_inst);
        chk("din_keep", bus.mem_din, exp_din);
    endtask
    initial begin
        rst = 1'b0;
        bus.inst_ren = 0; bus.inst_addr = 0; bus.mem_ren = 0; bus.mem_wen = 0;
        bus.mem_addr = 0; bus.mem_dout = 0; bus.ram_rdata = 0; bus.ram_ack = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", 32'(bus.ram_req), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_inst", bus.inst_data, 0);
        chk("rst_din", bus.mem_din, 0);
        chk("rst_err", 32'(bus.arb_err), 0);
        rst = 1'b1;
        run_scn(1, 0, 0, 32'h0000_0040, 0, 0, 32'h2008_0005, 3, 0);
        chk("fetch_word", bus.inst_data, 32'h2008_0005);
        run_scn(1, 1, 0, 32'h0000_0100, 32'h0000_0200, 0, 0, 1, 1);
        run_scn(0, 1, 1, 0, 32'h0000_0010, 32'hA5A5_A5A5, 0, 0, 2);
        run_scn(0, 1, 0, 0, 32'h0000_0020, 0, 0, 0, 9);
        chk("abort_din", bus.mem_din, ABORT);
        run_scn(1, 1, 0, 32'h0000_0104, 32'h0000_0204, 0, 0, T, T + 1);
        for (int i = 0; i < 40; i++) begin
            bit di, dd;
            di = 1'($urandom_range(0, 1));
            dd = di ? 1'($urandom_range(0, 1)) : 1'b1;
            run_scn(di, dd, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 0,
                    $urandom_range(1, 6), $urandom_range(1, 6));
        end
        @(negedge clk);
        bus.mem_ren  = 1'b1;
        bus.mem_addr = 32'h0000_0300;
        repeat (2) @(negedge clk);
        #1;
        chk("busy_req", 32'(bus.ram_req), 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.ram_req), 0);
        chk("mid_rst_addr", bus.ram_addr, 0);
        chk("mid_rst_din", bus.mem_din, 0);
        chk("mid_rst_inst", bus.inst_data, 0);
        chk("mid_rst_err", 32'(bus.arb_err), 0);
        bus.mem_ren = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.ram_ack = 1'b0;
        #1;
        chk("late_ack_req", 32'(bus.ram_req), 0);
        chk("late_ack_din", bus.mem_din, 0);
        chk("late_ack_stall", 32'(bus.mem_stall), 0);
        exp_inst = '0;
        exp_din  = '0;
        exp_err  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d = 1'b0;
`endif
        run_scn(1, 1, 0, 32'h0000_0400, 32'h0000_0500, 0, 0, 2, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
